// File: rtl/struct_neural_pkg.sv
// ==== struct_neural_pkg : Q8.8 types, constants and activation helpers (rev 1.0) ====
`default_nettype none

package struct_neural_pkg;

  localparam int Q_W   = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 2 * Q_W + 1;

  typedef logic signed [Q_W-1:0]   q8_8_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam q8_8_t Q_ONE  = 16'sh0100;
  localparam q8_8_t Q_HALF = 16'sh0080;

  localparam acc_t SAT_MAX = acc_t'(32767);
  localparam acc_t SAT_MIN = acc_t'(-32768);

  // 0.5 + s/4, clamped to [0.0, 1.0]; the shift floors toward -inf
  function automatic q8_8_t hard_sigmoid(input acc_t s);
    acc_t y;
    y = (s >>> 2) + acc_t'(Q_HALF);
    if (y[ACC_W-1])
      return '0;
    else if (y > acc_t'(Q_ONE))
      return Q_ONE;
    else
      return y[Q_W-1:0];
  endfunction

  function automatic q8_8_t saturate(input acc_t s);
    if (s > SAT_MAX)
      return 16'sh7FFF;
    else if (s < SAT_MIN)
      return 16'sh8000;
    else
      return s[Q_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/struct_neural_neuron.sv
// ==== struct_neuron : combinational 2-input Q8.8 MAC with sigmoid or linear activation (rev 1.0) ====
`default_nettype none

module struct_neuron
  import struct_neural_pkg::*;
#(
  parameter int SHIFT  = 8,
  parameter bit LINEAR = 1'b0
) (
  input  q8_8_t xa,
  input  q8_8_t xb,
  input  q8_8_t wa,
  input  q8_8_t wb,
  output q8_8_t y
);

  logic signed [2*Q_W-1:0] prod_a;
  logic signed [2*Q_W-1:0] prod_b;
  acc_t                    sum;
  acc_t                    s;

  // Operands widened before multiply/add so 0x8000*0x8000 + 0x8000*0x8000 cannot wrap
  always_comb begin
    prod_a = (2*Q_W)'(xa) * (2*Q_W)'(wa);
    prod_b = (2*Q_W)'(xb) * (2*Q_W)'(wb);
    sum    = acc_t'(prod_a) + acc_t'(prod_b);
    s      = sum >>> SHIFT;
  end

  if (LINEAR) begin : g_linear
    assign y = saturate(s);
  end else begin : g_sigmoid
    assign y = hard_sigmoid(s);
  end

endmodule

`default_nettype wire

// File: rtl/struct_neural.sv
// ==== struct_neural : 2-2-2 Q8.8 feed-forward network, 2-stage pipeline (rev 1.0) ====
// ==== Define STRUCT_NEURAL_LINEAR_OUT_EN for a linear, saturated output layer ====
`default_nettype none

module struct_neural #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] inputA,
  input  logic [W-1:0] inputB,
  input  logic [W-1:0] c111,
  input  logic [W-1:0] c112,
  input  logic [W-1:0] c121,
  input  logic [W-1:0] c122,
  input  logic [W-1:0] c211,
  input  logic [W-1:0] c212,
  input  logic [W-1:0] c221,
  input  logic [W-1:0] c222,
  output logic         out_valid,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2
);

  import struct_neural_pkg::*;

`ifdef STRUCT_NEURAL_LINEAR_OUT_EN
  localparam bit OUT_LINEAR = 1'b1;
`else
  localparam bit OUT_LINEAR = 1'b0;
`endif

  q8_8_t h1_w, h2_w, out1_w, out2_w;

  q8_8_t h1_q, h1_d, h2_q, h2_d;
  q8_8_t c211_q, c211_d, c212_q, c212_d, c221_q, c221_d, c222_q, c222_d;
  q8_8_t out1_q, out1_d, out2_q, out2_d;
  logic  valid1_q, valid1_d, out_valid_q, out_valid_d;

  struct_neuron #(.SHIFT(FRAC), .LINEAR(1'b0)) u_h1 (
    .xa(inputA), .xb(inputB), .wa(c111), .wb(c112), .y(h1_w)
  );
  struct_neuron #(.SHIFT(FRAC), .LINEAR(1'b0)) u_h2 (
    .xa(inputA), .xb(inputB), .wa(c121), .wb(c122), .y(h2_w)
  );
  struct_neuron #(.SHIFT(FRAC), .LINEAR(OUT_LINEAR)) u_o1 (
    .xa(h1_q), .xb(h2_q), .wa(c211_q), .wb(c212_q), .y(out1_w)
  );
  struct_neuron #(.SHIFT(FRAC), .LINEAR(OUT_LINEAR)) u_o2 (
    .xa(h1_q), .xb(h2_q), .wa(c221_q), .wb(c222_q), .y(out2_w)
  );

  // Layer-2 weights travel with their sample so in-flight data keeps its own weights
  always_comb begin
    h1_d        = h1_q;
    h2_d        = h2_q;
    c211_d      = c211_q;
    c212_d      = c212_q;
    c221_d      = c221_q;
    c222_d      = c222_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    valid1_d    = in_valid;
    out_valid_d = valid1_q;
    if (in_valid) begin
      h1_d   = h1_w;
      h2_d   = h2_w;
      c211_d = c211;
      c212_d = c212;
      c221_d = c221;
      c222_d = c222;
    end
    if (valid1_q) begin
      out1_d = out1_w;
      out2_d = out2_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q        <= '0;
      h2_q        <= '0;
      c211_q      <= '0;
      c212_q      <= '0;
      c221_q      <= '0;
      c222_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      valid1_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      c211_q      <= c211_d;
      c212_q      <= c212_d;
      c221_q      <= c221_d;
      c222_q      <= c222_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      valid1_q    <= valid1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out1      = out1_q;
  assign out2      = out2_q;

endmodule

`default_nettype wire

// File: tb/tb_struct_neural.sv
// ==== tb_struct_neural : scoreboard bench for struct_neural (rev 1.0) ====
`default_nettype none

module tb_struct_neural;

`ifdef STRUCT_NEURAL_LINEAR_OUT_EN
  localparam bit LIN = 1'b1;
`else
  localparam bit LIN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] inputA = '0, inputB = '0;
  logic [15:0] c111 = '0, c112 = '0, c121 = '0, c122 = '0;
  logic [15:0] c211 = '0, c212 = '0, c221 = '0, c222 = '0;
  logic        out_valid;
  logic [15:0] out1, out2;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [15:0] last1 = '0, last2 = '0;
  bit   [1:0]  hist = '0;

  struct_neural dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .inputA(inputA), .inputB(inputB),
    .c111(c111), .c112(c112), .c121(c121), .c122(c122),
    .c211(c211), .c212(c212), .c221(c221), .c222(c222),
    .out_valid(out_valid), .out1(out1), .out2(out2)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [15:0] a, b, w111, w112, w121, w122,
                      input logic [15:0] w211, w212, w221, w222,
                      input logic [15:0] s1, s2, l1, l2);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    inputA = a; inputB = b;
    c111 = w111; c112 = w112; c121 = w121; c122 = w122;
    c211 = w211; c212 = w212; c221 = w221; c222 = w222;
    exp_q.push_back(LIN ? {l1, l2} : {s1, s2});
  endtask

  // Inputs scrambled while idle: nothing may be sampled without in_valid
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inputA = 16'($urandom); inputB = 16'($urandom);
      c111 = 16'($urandom); c112 = 16'($urandom);
      c121 = 16'($urandom); c122 = 16'($urandom);
      c211 = 16'($urandom); c212 = 16'($urandom);
      c221 = 16'($urandom); c222 = 16'($urandom);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      hist  = '0;
      last1 = '0;
      last2 = '0;
    end else begin
      if (mon_en) begin
        checks++;
        if (out_valid !== hist[1]) begin
          errors++;
          $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, hist[1]);
        end
        if (out_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result @%0t: got %h/%h with empty scoreboard", $time, out1, out2);
          end else begin
            e = exp_q.pop_front();
            if (out1 !== e[31:16] || out2 !== e[15:0]) begin
              errors++;
              $display("FAIL result @%0t: got out1=%h out2=%h expected out1=%h out2=%h",
                       $time, out1, out2, e[31:16], e[15:0]);
            end
            last1 = e[31:16];
            last2 = e[15:0];
          end
        end else begin
          checks++;
          if (out1 !== last1 || out2 !== last2) begin
            errors++;
            $display("FAIL hold @%0t: got out1=%h out2=%h expected out1=%h out2=%h",
                     $time, out1, out2, last1, last2);
          end
        end
      end
      hist = {hist[0], in_valid};
    end
  end

  task automatic check_reset_state(input string name);
    checks++;
    if (out1 !== 16'h0000 || out2 !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: got out1=%h out2=%h out_valid=%b expected 0000/0000/0",
               name, out1, out2, out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_state("reset_initial");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // zeros, all ones, partial layer-1, layer-2 variations (back-to-back)
    send(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
         16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0080, 16'h0000, 16'h0000);
    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
         16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200);
    send(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100,
         16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h00E0, 16'h00E0, 16'h0180, 16'h0180);
    send(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100,
         16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h00A0, 16'h00A0, 16'h0080, 16'h0080);
    idle(1);
    send(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
         16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h00C0, 16'h00C0, 16'h0100, 16'h0100);
    idle(2);
    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
         16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0080, 16'h0100, 16'h0000, 16'h0200);
    // most negative operands everywhere: hidden = 1.0, output sum = -256.0
    send(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
         16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h8000);
    idle(1);
    send(16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000,
         16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0080, 16'h0000, 16'h0000);
    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
         16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0100, 16'h0100, 16'h0800, 16'h0800);
    // -1/256 floors to -1 in the hidden sum, giving h1 = 0x007F
    send(16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
         16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h009F, 16'h00A0, 16'h007F, 16'h0080);
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
         16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100, 16'h7FFF, 16'h7FFF);
    idle(4);

    // reset with two samples in flight: both must vanish
    send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
         16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200);
    send(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
         16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h00C0, 16'h00C0, 16'h0100, 16'h0100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1 check_reset_state("reset_midstream");
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(4);

    send(16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100,
         16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h00E0, 16'h00E0, 16'h0180, 16'h0180);
    idle(1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
    end
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
